// File: rtl/phys_mem_ctrl.sv
// phys_mem_ctrl: responder for the CPU's physical memory port. Each new request becomes one
// timed async-SRAM read or write cycle: SETUP (1 cycle), PULSE (WAIT_CYCLES cycles), RECOVER
// (1 cycle). There is no request strobe. An access starts whenever the presented request
// differs from the last one completed, which is held in a tag register.
//
// Optional feature: define PHYS_MEM_STAT_EN to build completed-read and completed-write
// counters. With the macro undefined, both stat outputs are tied to zero and no counter flops
// are built.
//
// Ports:
//   clk_i, rst_ni     clock (rising edge) and asynchronous active-low reset
//   cpu_addr_i        byte address; bits [1:0] are ignored
//   cpu_wdata_i       write data
//   cpu_is_write_i    1 = write, 0 = read
//   cpu_rdata_o       registered read data
//   cpu_busy_o        request pending or in flight
//   ram_addr_o        SRAM word address (registered)
//   ram_wdata_o       SRAM write data (registered)
//   ram_rdata_i       SRAM read data
//   ram_data_oe_o     drive ram_wdata_o onto the SRAM data bus
//   ram_ce_n_o        SRAM chip enable, active low
//   ram_oe_n_o        SRAM output enable, active low
//   ram_we_n_o        SRAM write enable, active low
//   stat_rd_cnt_o     number of completed reads
//   stat_wr_cnt_o     number of completed writes
module phys_mem_ctrl #(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_is_write_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_busy_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic              ram_data_oe_o,
    output logic              ram_ce_n_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic [31:0]       stat_rd_cnt_o,
    output logic [31:0]       stat_wr_cnt_o
);

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StRecover} state_e;

    // The pulse counter is loaded with WAIT_CYCLES-1 and the last PULSE cycle is the one
    // where it reads zero.
    localparam logic [3:0] PulseLoad = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Captured request. The full word address is kept so that the tag compares all 30 bits,
    // even though only ADDR_W of them reach the SRAM.
    logic [29:0] req_addr_q;
    logic        op_write_q;
    logic [31:0] ram_wdata_q;
    logic [31:0] rdata_q;

    // The last completed request.
    logic        tag_valid_q;
    logic [29:0] tag_addr_q;
    logic        tag_we_q;
    logic [31:0] tag_data_q;

    logic        mismatch;
    logic        capture;
    logic        rd_load;
    logic        tag_load;

    // The byte-lane bits of the address are not used by a word-wide SRAM.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // Write data only matters for writes. For a repeated read, stale wdata must not retrigger.
    assign mismatch = !tag_valid_q
                    | (cpu_addr_i[31:2] != tag_addr_q)
                    | (cpu_is_write_i != tag_we_q)
                    | (cpu_is_write_i & (cpu_wdata_i != tag_data_q));

    assign cpu_busy_o = (state_q != StIdle) | mismatch;

    // The strobes decode combinationally from the state register. An asynchronous reset of
    // the state therefore releases them immediately, without waiting for a clock edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        capture       = 1'b0;
        rd_load       = 1'b0;
        tag_load      = 1'b0;
        ram_ce_n_o    = 1'b1;
        ram_oe_n_o    = 1'b1;
        ram_we_n_o    = 1'b1;
        ram_data_oe_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (mismatch) begin
                    capture = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                ram_ce_n_o    = 1'b0;
                ram_data_oe_o = op_write_q;
                cnt_d         = PulseLoad;
                state_d       = StPulse;
            end
            StPulse: begin
                ram_ce_n_o = 1'b0;
                if (op_write_q) begin
                    ram_we_n_o    = 1'b0;
                    ram_data_oe_o = 1'b1;
                end else begin
                    ram_oe_n_o = 1'b0;
                end
                if (cnt_q == 4'd0) begin
                    rd_load = !op_write_q;
                    state_d = StRecover;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecover: begin
                // Chip enable and the write data are held for one cycle after the strobe
                // rises.
                ram_ce_n_o    = 1'b0;
                ram_data_oe_o = op_write_q;
                tag_load      = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_addr_q  <= '0;
            op_write_q  <= 1'b0;
            ram_wdata_q <= '0;
        end else if (capture) begin
            req_addr_q  <= cpu_addr_i[31:2];
            op_write_q  <= cpu_is_write_i;
            ram_wdata_q <= cpu_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rd_load) begin
            rdata_q <= ram_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
            tag_we_q    <= 1'b0;
            tag_data_q  <= '0;
        end else if (tag_load) begin
            tag_valid_q <= 1'b1;
            tag_addr_q  <= req_addr_q;
            tag_we_q    <= op_write_q;
            tag_data_q  <= ram_wdata_q;
        end
    end

    assign ram_addr_o  = req_addr_q[ADDR_W-1:0];
    assign ram_wdata_o = ram_wdata_q;
    assign cpu_rdata_o = rdata_q;

`ifdef PHYS_MEM_STAT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    // An access counts once, in its RECOVER cycle. The counters wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (tag_load) begin
            if (op_write_q) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign stat_rd_cnt_o = rd_cnt_q;
    assign stat_wr_cnt_o = wr_cnt_q;
`else
    assign stat_rd_cnt_o = '0;
    assign stat_wr_cnt_o = '0;
`endif

endmodule
